// File: rtl/stopwatch_counter_if.sv
// Control and display bundle for the stopwatch counter.
// master drives the control pulses, slave drives the count.
interface stopwatch_counter_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       running;
  logic       tick_pulse;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic       rollover;

  modport master (
    output start, stop, clear,
    input  running, tick_pulse, rollover,
    input  sec_ones, sec_tens, min_ones, min_tens
  );

  modport slave (
    input  start, stop, clear,
    output running, tick_pulse, rollover,
    output sec_ones, sec_tens, min_ones, min_tens
  );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch: synchronises the divided clock, prescales its edges
// and advances a run/pause/clear controlled BCD MM:SS counter.
module stopwatch_counter #(
  parameter int TICKS_PER_COUNT = 4,
  parameter int CNT_W           = 16
) (
  input logic clk_in,
  input logic rst_n,
  input logic tick_src,
  stopwatch_counter_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_e;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TICKS_PER_COUNT - 1);

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q, tp_q;

  logic [CNT_W-1:0] pre_q, pre_d;
  logic [3:0] so_q, so_d;
  logic [2:0] st_q, st_d;
  logic [3:0] mo_q, mo_d;
  logic [2:0] mt_q, mt_d;
  logic       roll_q, roll_d;

  logic adv;
  logic inc;

  // tick_src is data only; s3 remembers s2 for edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      tp_q <= 1'b0;
    end else begin
      s1_q <= tick_src;
      s2_q <= s1_q;
      s3_q <= s2_q;
      tp_q <= s2_q & ~s3_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sw.clear) begin
      state_d = IDLE;
    end else if (sw.stop && state_q == RUN) begin
      state_d = PAUSED;
    end else if (sw.start && state_q != RUN) begin
      state_d = RUN;
    end
  end

  assign adv = tp_q && (state_q == RUN) && !sw.clear;
  assign inc = adv && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (sw.clear || state_q == IDLE) begin
      pre_d = '0;
    end else if (adv) begin
      pre_d = inc ? '0 : pre_q + CNT_W'(1);
    end
  end

  // Each digit carries on equality with its own limit
  always_comb begin
    so_d   = so_q;
    st_d   = st_q;
    mo_d   = mo_q;
    mt_d   = mt_q;
    roll_d = 1'b0;
    if (sw.clear) begin
      so_d = '0;
      st_d = '0;
      mo_d = '0;
      mt_d = '0;
    end else if (inc) begin
      so_d = (so_q == 4'd9) ? 4'd0 : so_q + 4'd1;
      if (so_q == 4'd9) begin
        st_d = (st_q == 3'd5) ? 3'd0 : st_q + 3'd1;
        if (st_q == 3'd5) begin
          mo_d = (mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
          if (mo_q == 4'd9) begin
            mt_d   = (mt_q == 3'd5) ? 3'd0 : mt_q + 3'd1;
            roll_d = (mt_q == 3'd5);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      so_q    <= '0;
      st_q    <= '0;
      mo_q    <= '0;
      mt_q    <= '0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      so_q    <= so_d;
      st_q    <= st_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
      roll_q  <= roll_d;
    end
  end

  assign sw.running    = (state_q == RUN);
  assign sw.tick_pulse = tp_q;
  assign sw.sec_ones   = so_q;
  assign sw.sec_tens   = st_q;
  assign sw.min_ones   = mo_q;
  assign sw.min_tens   = mt_q;
  assign sw.rollover   = roll_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: vector table, corner sequences
// and random traffic against a seconds-count reference model.
`timescale 1ns/1ps
module tb_stopwatch_counter;

  localparam int TPC = 4;

  logic clk_in = 1'b0;
  logic rst_n;
  logic tick_src;

  stopwatch_counter_if sw();

  stopwatch_counter #(
    .TICKS_PER_COUNT(TPC),
    .CNT_W(16)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .tick_src(tick_src),
    .sw(sw)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // reference model: state 0 idle, 1 run, 2 paused
  int m_state;
  int m_pre;
  int m_secs;
  bit m_tp;
  bit m_roll;
  bit hist[4];
  int roll_seen;
  bit src_t;

  typedef struct {
    bit src, st, sp, cl;
    bit run, tp;
    logic [3:0] so;
  } vec_t;
  vec_t tv[17];

  task automatic chk(input string nm,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {sw.running, sw.tick_pulse, sw.rollover,
            sw.sec_ones, sw.sec_tens,
            sw.min_ones, sw.min_tens};
  endfunction

  function automatic logic [16:0] m_outs();
    return {m_state == 1, m_tp, m_roll,
            4'(m_secs % 10), 3'((m_secs / 10) % 6),
            4'((m_secs / 60) % 10), 3'(m_secs / 600)};
  endfunction

  task automatic m_reset();
    m_state = 0;
    m_pre   = 0;
    m_secs  = 0;
    m_tp    = 0;
    m_roll  = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
  endtask

  task automatic m_edge(input bit src, st, sp, cl);
    bit inc;
    inc = 0;
    if (cl) begin
      m_pre  = 0;
      m_secs = 0;
    end else if (m_state == 0) begin
      m_pre = 0;
    end else if (m_state == 1 && m_tp) begin
      m_pre++;
      if (m_pre == TPC) begin
        m_pre = 0;
        inc   = 1;
      end
    end
    m_roll = inc && (m_secs == 3599);
    if (inc) m_secs = (m_secs + 1) % 3600;
    if (cl) m_state = 0;
    else if (sp && m_state == 1) m_state = 2;
    else if (st && m_state != 1) m_state = 1;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = src;
    m_tp = hist[2] & ~hist[3];
  endtask

  task automatic step(input bit src, st, sp, cl);
    tick_src = src;
    sw.start = st;
    sw.stop  = sp;
    sw.clear = cl;
    @(posedge clk_in);
    m_edge(src, st, sp, cl);
    #1;
    sw.start = 0;
    sw.stop  = 0;
    sw.clear = 0;
    if (sw.rollover) roll_seen++;
    chk("model", int'(outs()), int'(m_outs()));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n    = 0;
    tick_src = 0;
    sw.start = 0;
    sw.stop  = 0;
    sw.clear = 0;
    m_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1;
  endtask

  // step with a toggling tick_src until an increment is due
  task automatic seek_due(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_tp && m_state == 1 && m_pre == TPC - 1) begin
        ok = 1;
        break;
      end
      src_t = ~src_t;
      step(src_t, 0, 0, 0);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL seek_due: got 0 want 1");
    end
  endtask

  initial begin
    bit ok;
    int npulse;
    src_t = 0;
    tv[0]  = '{0,0,0,0, 0,0, 0};
    tv[1]  = '{1,1,0,0, 1,0, 0};
    tv[2]  = '{1,0,0,0, 1,0, 0};
    tv[3]  = '{1,0,0,0, 1,1, 0};
    tv[4]  = '{1,0,0,0, 1,0, 0};
    tv[5]  = '{0,0,0,0, 1,0, 0};
    tv[6]  = '{1,0,0,0, 1,0, 0};
    tv[7]  = '{0,0,0,0, 1,0, 0};
    tv[8]  = '{0,0,0,0, 1,1, 0};
    tv[9]  = '{1,0,0,0, 1,0, 0};
    tv[10] = '{0,0,0,0, 1,0, 0};
    tv[11] = '{0,0,0,0, 1,1, 0};
    tv[12] = '{1,0,1,0, 0,0, 0};
    tv[13] = '{0,1,0,0, 1,0, 0};
    tv[14] = '{0,0,0,0, 1,1, 0};
    tv[15] = '{0,0,0,0, 1,0, 1};
    tv[16] = '{0,0,0,1, 0,0, 0};

    do_reset();
    chk("reset_outs", int'(outs()), 0);

    for (int i = 0; i < 17; i++) begin
      step(tv[i].src, tv[i].st, tv[i].sp, tv[i].cl);
      chk($sformatf("vec%0d_run", i),
          int'(sw.running), int'(tv[i].run));
      chk($sformatf("vec%0d_tp", i),
          int'(sw.tick_pulse), int'(tv[i].tp));
      chk($sformatf("vec%0d_so", i),
          int'(sw.sec_ones), int'(tv[i].so));
    end

    // held-high source yields one pulse, two cycles late
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      if (sw.tick_pulse) npulse++;
      if (i == 2) chk("lat_pulse", int'(sw.tick_pulse), 1);
    end
    chk("hold_one_pulse", npulse, 1);
    repeat (3) step(0, 0, 0, 0);

    step(0, 1, 0, 0);
    ticks(4);
    chk("cnt4_so", int'(sw.sec_ones), 1);
    ticks(36);
    chk("cnt40_st", int'(sw.sec_tens), 1);
    chk("cnt40_so", int'(sw.sec_ones), 0);

    ticks(2);
    step(0, 0, 1, 0);
    ticks(3);
    chk("pause_hold", int'(sw.sec_ones), 0);
    chk("pause_run", int'(sw.running), 0);
    step(0, 1, 0, 0);
    ticks(1);
    chk("resume_part", int'(sw.sec_ones), 0);
    ticks(1);
    chk("resume_inc", int'(sw.sec_ones), 1);

    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(28);
    chk("pre_rst_so", int'(sw.sec_ones), 7);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst", int'(outs()), 0);
    m_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      chk("post_rst_tp", int'(sw.tick_pulse), 0);
    end
    chk("post_rst_run", int'(sw.running), 0);

    step(0, 1, 0, 0);
    ticks(2);
    step(0, 1, 1, 1);
    chk("prio_run", int'(sw.running), 0);
    chk("prio_cnt", int'(outs()), 0);

    step(0, 1, 0, 0);
    seek_due(ok);
    step(src_t, 0, 0, 1);
    chk("clr_inc_so", int'(sw.sec_ones), 0);
    chk("clr_inc_roll", int'(sw.rollover), 0);

    step(0, 1, 0, 0);
    seek_due(ok);
    step(src_t, 0, 1, 0);
    chk("stop_inc_so", int'(sw.sec_ones), 1);
    chk("stop_inc_run", int'(sw.running), 0);

    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(3599 * TPC);
    chk("at_5959", int'({sw.min_tens, sw.min_ones,
                         sw.sec_tens, sw.sec_ones}),
        int'({3'd5, 4'd9, 3'd5, 4'd9}));
    roll_seen = 0;
    ticks(TPC);
    chk("wrap_roll", roll_seen, 1);
    chk("wrap_zero", int'({sw.min_tens, sw.min_ones,
                           sw.sec_tens, sw.sec_ones}), 0);
    chk("wrap_run", int'(sw.running), 1);

    step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 127) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Consumes the divided clock produced by the clock-divider stage. That clock is treated as a data signal (tick_src) and is never used as a clock. The block synchronises tick_src into the clk_in domain, detects its rising edges and prescales them. Each prescaled event advances a run/pause/clear-controlled BCD MM:SS counter, which feeds the display driver.

Parameters:
TICKS_PER_COUNT, 4, tick_src rising edges per one-second increment; legal range 1..65535.
CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= TICKS_PER_COUNT.

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
tick_src  input  1  divided clock from the divider stage; asynchronous to clk_in logic
start  input  1  single-cycle pulse: begin or resume counting
stop  input  1  single-cycle pulse: pause counting
clear  input  1  single-cycle pulse: zero the counter and return to IDLE
running  output  1  high while in state RUN
tick_pulse  output  1  one-cycle pulse per synchronised tick_src rising edge
sec_ones  output  4  BCD seconds units, 0..9
sec_tens  output  3  BCD seconds tens, 0..5
min_ones  output  4  BCD minutes units, 0..9
min_tens  output  3  BCD minutes tens, 0..5
rollover  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; synchroniser flops, edge register and prescaler cleared; state IDLE. Reset asserted mid-run has the same effect immediately. After release, the first action occurs on the next clk_in edge.
- Synchroniser: two flops (s1, s2) plus an edge register s3.
  - tick_pulse is registered: tick_pulse <= s2 & ~s3.
  - Latency: tick_src high sampled at edge N -> tick_pulse high during the cycle after edge N+2, for exactly 1 cycle.
  - tick_pulse fires in every state, including IDLE and PAUSED.
- FSM states are IDLE, RUN and PAUSED.
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSED.
  - PAUSED: start -> RUN.
  - Any state: clear -> IDLE.
  - Priority when several pulses coincide: clear > stop > start.
  - start in RUN, and stop in IDLE or PAUSED, are ignored.
  - running is combinational from the state: 1 iff RUN.
- Prescaler: advances only when tick_pulse is high and state is RUN at that edge.
  - If prescaler == TICKS_PER_COUNT-1: prescaler <= 0 and an increment occurs.
  - Otherwise: prescaler <= prescaler + 1.
  - The prescaler holds its value in PAUSED, so a resume continues the partial count. It is zeroed in IDLE and on clear.
  - TICKS_PER_COUNT=1: every tick_pulse in RUN increments.
- BCD increment:
  - sec_ones increments; on 9 it wraps to 0 and carries into sec_tens.
  - sec_tens wraps at 5 and carries into min_ones; min_ones wraps at 9 and carries into min_tens; min_tens wraps at 5.
  - From 59:59 an increment gives 00:00 and rollover=1 for that one cycle; state stays RUN.
  - Digits update on the same edge the increment is decided, i.e. the edge where the final tick_pulse is high in RUN.
- Simultaneous events:
  - stop on the edge where an increment is due: the increment is applied, then the state goes to PAUSED.
  - clear on that edge: clear wins; no increment, no rollover, digits go to 0.
  - start in IDLE on the same edge as a tick_pulse: the tick is not counted, because the state was IDLE at that edge.
- Digits never take non-BCD values; increment logic uses equality-to-limit compares, not binary overflow.

Test Plan:
- Reset: drive rst_n=0 mid-run at count 00:07 -> all outputs 0 and running=0 within the same cycle; after release the state is IDLE and tick_pulse stays 0 until a new tick_src edge.
- Sync latency: tick_src rises before edge N -> tick_pulse=1 only in the cycle after edge N+2; holding tick_src high for 10 cycles still gives exactly one pulse.
- Counting (TICKS_PER_COUNT=4): start, then 4 tick_src edges -> sec_ones=1 on the edge of the 4th tick_pulse; 40 edges -> 00:10 (sec_tens=1, sec_ones=0).
- Pause/resume: after 2 ticks into a second, stop -> 3 further edges leave the count unchanged; start, then 2 more edges -> increment occurs; the prescaler remainder was held.
- Wrap: preload via 3599*4 edges to 59:59, then 4 more edges -> 00:00, rollover=1 for exactly one cycle, running stays 1.
- Priority: start+stop+clear on one edge in RUN -> IDLE, count 00:00; clear on an increment edge -> no increment, no rollover; stop on an increment edge -> digit advances, then PAUSED.
